// File: rtl/stoch_arith_unit.sv
// stoch_arith_unit: turns two binary probabilities into LFSR-driven bitstreams, combines them
// in one of four modes and counts the result back to binary over a gapless 2^WIN_LOG2 window.
module stoch_arith_unit #(
  parameter int          PW       = 4,
  parameter int          WIN_LOG2 = 3,
  parameter logic [30:0] SEED_A   = 31'd1,
  parameter logic [30:0] SEED_B   = 31'd2,
  parameter logic [30:0] SEED_C   = 31'h5A5A5A5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [PW-1:0]       prob_a,
  input  logic [PW-1:0]       prob_b,
  input  logic [1:0]          mode,
  output logic [WIN_LOG2:0]   result,
  output logic                result_valid,
  output logic                busy
);

  localparam logic [1:0] MODE_AND  = 2'b00;
  localparam logic [1:0] MODE_XNOR = 2'b01;
  localparam logic [1:0] MODE_MUX  = 2'b10;
  localparam logic [1:0] MODE_PASS = 2'b11;

  localparam logic [WIN_LOG2-1:0] CNT_ONE = WIN_LOG2'(1);

  // x^31 + x^28 + 1 Fibonacci step: shift up, feed q[30]^q[27] into bit 0
  function automatic logic [30:0] lfsrStep(input logic [30:0] q);
    return {q[29:0], q[30] ^ q[27]};
  endfunction

  logic [30:0]         r_lfsrA, r_lfsrB, r_lfsrC;
  logic [WIN_LOG2-1:0] r_cnt0;
  logic [PW-1:0]       r_shPa, r_shPb;
  logic [1:0]          r_shMode;
  logic                r_sa, r_sb, r_sel, r_v1, r_last1;
  logic [1:0]          r_mode1;
  logic                r_op, r_v2, r_last2;
  logic [WIN_LOG2:0]   r_acc, r_result;
  logic                r_resultValid;

  logic                w_winStart;
  logic [PW-1:0]       w_pa, w_pb;
  logic [1:0]          w_mode;
  logic                w_op;
  logic [WIN_LOG2:0]   w_accNext;

  // The first bit of a window sees the live inputs; the rest use the shadow copy
  assign w_winStart = (r_cnt0 == '0);
  assign w_pa       = w_winStart ? prob_a : r_shPa;
  assign w_pb       = w_winStart ? prob_b : r_shPb;
  assign w_mode     = w_winStart ? mode   : r_shMode;
  assign w_accNext  = r_acc + {{WIN_LOG2{1'b0}}, r_op};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsrA  <= SEED_A;
      r_lfsrB  <= SEED_B;
      r_lfsrC  <= SEED_C;
      r_cnt0   <= '0;
      r_shPa   <= '0;
      r_shPb   <= '0;
      r_shMode <= '0;
    end else if (en) begin
      r_lfsrA <= lfsrStep(r_lfsrA);
      r_lfsrB <= lfsrStep(r_lfsrB);
      r_lfsrC <= lfsrStep(r_lfsrC);
      r_cnt0  <= r_cnt0 + CNT_ONE;
      if (w_winStart) begin
        r_shPa   <= prob_a;
        r_shPb   <= prob_b;
        r_shMode <= mode;
      end
    end else begin
      r_cnt0 <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_sel   <= 1'b0;
      r_mode1 <= '0;
      r_v1    <= 1'b0;
      r_last1 <= 1'b0;
    end else begin
      r_sa    <= (r_lfsrA[PW-1:0] < w_pa);
      r_sb    <= (r_lfsrB[PW-1:0] < w_pb);
      r_sel   <= r_lfsrC[0];
      r_mode1 <= w_mode;
      r_v1    <= en;
      r_last1 <= en & (&r_cnt0);
    end
  end

  always_comb begin
    w_op = 1'b0;
    case (r_mode1)
      MODE_AND:  w_op = r_sa & r_sb;
      MODE_XNOR: w_op = ~(r_sa ^ r_sb);
      MODE_MUX:  w_op = r_sel ? r_sb : r_sa;
      MODE_PASS: w_op = r_sa;
      default:   w_op = 1'b0;
    endcase
  end

  // Dropping en flushes in-flight bits so a partial window is never counted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= 1'b0;
      r_v2    <= 1'b0;
      r_last2 <= 1'b0;
    end else begin
      r_op    <= w_op;
      r_v2    <= en & r_v1;
      r_last2 <= en & r_last1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc         <= '0;
      r_result      <= '0;
      r_resultValid <= 1'b0;
    end else if (!en) begin
      r_acc         <= '0;
      r_resultValid <= 1'b0;
    end else if (r_v2 && r_last2) begin
      r_result      <= w_accNext;
      r_resultValid <= 1'b1;
      r_acc         <= '0;
    end else begin
      r_resultValid <= 1'b0;
      if (r_v2) r_acc <= w_accNext;
    end
  end

  assign result       = r_result;
  assign result_valid = r_resultValid;
  assign busy         = r_v1 | r_v2;

endmodule
